// File: rtl/vend_change_payout.sv
// rtl/vend_change_payout.sv - change payout controller for a two-tube (5/10 rupee) coin hopper
//
// Pays a change-due request (units of 5 rupees) one coin at a time, largest coin first,
// using an eject pulse / coin sense handshake, and keeps a saturating inventory per tube.
// Whatever cannot be paid from the tubes is reported as shortfall.
//
// Ports
//   clk            clock, rising edge
//   rst            asynchronous active-high reset
//   req_valid_i    change request valid
//   req_amount_i   change due, units of 5 rupees
//   req_ready_o    high only while idle; request taken on req_valid_i & req_ready_o
//   load_five_i    add load_qty_i coins to the 5-rupee tube (idle only)
//   load_ten_i     add load_qty_i coins to the 10-rupee tube (idle only)
//   load_qty_i     refill quantity
//   eject_five_o   eject pulse for one 5-rupee coin
//   eject_ten_o    eject pulse for one 10-rupee coin
//   coin_sense_i   one-cycle pulse: a coin has left the active tube
//   clear_fault_i  leave the fault state
//   busy_o         high whenever not idle
//   done_o         one-cycle pulse when a request completes (fully paid or short)
//   shortfall_o    unpaid remainder of the last request
//   fault_o        high while in the fault state
//   five_count_o   coins in the 5-rupee tube
//   ten_count_o    coins in the 10-rupee tube

module vend_change_payout #(
   parameter int AMT_W       = 6,
   parameter int CNT_W       = 8,
   parameter int PULSE_CYC   = 4,
   parameter int TIMEOUT_CYC = 64
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_valid_i,
   input  logic [AMT_W-1:0] req_amount_i,
   output logic             req_ready_o,
   input  logic             load_five_i,
   input  logic             load_ten_i,
   input  logic [CNT_W-1:0] load_qty_i,
   output logic             eject_five_o,
   output logic             eject_ten_o,
   input  logic             coin_sense_i,
   input  logic             clear_fault_i,
   output logic             busy_o,
   output logic             done_o,
   output logic [AMT_W-1:0] shortfall_o,
   output logic             fault_o,
   output logic [CNT_W-1:0] five_count_o,
   output logic [CNT_W-1:0] ten_count_o
);

   typedef enum logic [2:0] {
      S_IDLE       = 3'd0,
      S_SELECT     = 3'd1,
      S_EJECT      = 3'd2,
      S_WAIT_SENSE = 3'd3,
      S_FINISH     = 3'd4,
      S_FAULT      = 3'd5
   } state_t;

   localparam int PW = (PULSE_CYC > 1) ? $clog2(PULSE_CYC) : 1;
   localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [PW-1:0] PULSE_LAST   = PW'(PULSE_CYC - 1);
   localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYC - 1);
   localparam logic [AMT_W-1:0] AMT_ONE   = AMT_W'(1);
   localparam logic [AMT_W-1:0] AMT_TWO   = AMT_W'(2);

   state_t           state_q, state_d;
   logic [AMT_W-1:0] rem_q, rem_d;
   logic             coin_ten_q, coin_ten_d;
   logic [PW-1:0]    pcnt_q, pcnt_d;
   logic [TW-1:0]    tcnt_q, tcnt_d;
   logic [CNT_W-1:0] five_q, five_d;
   logic [CNT_W-1:0] ten_q, ten_d;
   logic             eject_five_q, eject_five_d;
   logic             eject_ten_q, eject_ten_d;
   logic             busy_q, busy_d;
   logic             ready_q, ready_d;
   logic             done_q, done_d;
   logic             fault_q, fault_d;
   logic [AMT_W-1:0] short_q, short_d;

   // Refill add that sticks at the all-ones count instead of wrapping.
   function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                 input logic [CNT_W-1:0] b);
      logic [CNT_W:0] sum;
      sum = {1'b0, a} + {1'b0, b};
      return sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
   endfunction

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_IDLE;
         rem_q        <= '0;
         coin_ten_q   <= 1'b0;
         pcnt_q       <= '0;
         tcnt_q       <= '0;
         five_q       <= '0;
         ten_q        <= '0;
         eject_five_q <= 1'b0;
         eject_ten_q  <= 1'b0;
         busy_q       <= 1'b0;
         ready_q      <= 1'b1;
         done_q       <= 1'b0;
         fault_q      <= 1'b0;
         short_q      <= '0;
      end else begin
         state_q      <= state_d;
         rem_q        <= rem_d;
         coin_ten_q   <= coin_ten_d;
         pcnt_q       <= pcnt_d;
         tcnt_q       <= tcnt_d;
         five_q       <= five_d;
         ten_q        <= ten_d;
         eject_five_q <= eject_five_d;
         eject_ten_q  <= eject_ten_d;
         busy_q       <= busy_d;
         ready_q      <= ready_d;
         done_q       <= done_d;
         fault_q      <= fault_d;
         short_q      <= short_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      rem_d      = rem_q;
      coin_ten_d = coin_ten_q;
      pcnt_d     = pcnt_q;
      tcnt_d     = tcnt_q;
      five_d     = five_q;
      ten_d      = ten_q;
      short_d    = short_q;
      done_d     = 1'b0;

      case (state_q)
         S_IDLE: begin
            // Refills land on the same edge as an accept, so SELECT sees the new counts.
            if (load_five_i) begin
               five_d = sat_add(five_q, load_qty_i);
            end
            if (load_ten_i) begin
               ten_d = sat_add(ten_q, load_qty_i);
            end
            if (req_valid_i && ready_q) begin
               rem_d   = req_amount_i;
               short_d = '0;
               state_d = S_SELECT;
            end
         end

         S_SELECT: begin
            // Greedy: a ten only when at least two units remain, so rem never underflows.
            if ((rem_q >= AMT_TWO) && (ten_q != '0)) begin
               coin_ten_d = 1'b1;
               pcnt_d     = '0;
               state_d    = S_EJECT;
            end else if ((rem_q >= AMT_ONE) && (five_q != '0)) begin
               coin_ten_d = 1'b0;
               pcnt_d     = '0;
               state_d    = S_EJECT;
            end else begin
               state_d = S_FINISH;
            end
         end

         S_EJECT: begin
            if (pcnt_q == PULSE_LAST) begin
               tcnt_d  = '0;
               state_d = S_WAIT_SENSE;
            end else begin
               pcnt_d = pcnt_q + PW'(1);
            end
         end

         S_WAIT_SENSE: begin
            // A sense on the final allowed cycle still wins over the timeout.
            if (coin_sense_i) begin
               if (coin_ten_q) begin
                  rem_d = rem_q - AMT_TWO;
                  ten_d = ten_q - CNT_W'(1);
               end else begin
                  rem_d  = rem_q - AMT_ONE;
                  five_d = five_q - CNT_W'(1);
               end
               state_d = S_SELECT;
            end else if (tcnt_q == TIMEOUT_LAST) begin
               short_d = rem_q;
               state_d = S_FAULT;
            end else begin
               tcnt_d = tcnt_q + TW'(1);
            end
         end

         S_FINISH: begin
            short_d = rem_q;
            done_d  = 1'b1;
            state_d = S_IDLE;
         end

         S_FAULT: begin
            if (clear_fault_i) begin
               state_d = S_IDLE;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Status outputs are registered copies of the upcoming state.
      eject_five_d = (state_d == S_EJECT) && !coin_ten_d;
      eject_ten_d  = (state_d == S_EJECT) && coin_ten_d;
      busy_d       = (state_d != S_IDLE);
      ready_d      = (state_d == S_IDLE);
      fault_d      = (state_d == S_FAULT);
   end

   assign req_ready_o  = ready_q;
   assign eject_five_o = eject_five_q;
   assign eject_ten_o  = eject_ten_q;
   assign busy_o       = busy_q;
   assign done_o       = done_q;
   assign shortfall_o  = short_q;
   assign fault_o      = fault_q;
   assign five_count_o = five_q;
   assign ten_count_o  = ten_q;

endmodule
